// File: rtl/rng_code_sequencer_pkg.sv
// Shared definitions for the bomb-defuse code sequencer: state encoding,
// symbol width and the default code geometry.
package game_pkg;

    localparam int SYM_W = 2;

    localparam int DEF_LENGTH     = 4;
    localparam int DEF_SAMPLE_GAP = 5;
    localparam int DEF_MAX_REJECT = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        READY = 2'd2
    } seq_state_t;

    // Width needed to count 0..max_val inclusive, never less than one bit.
    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rng_code_sequencer_if.sv
// Handshake bundle between the game FSM / RNG and the code sequencer.
interface rng_code_sequencer_if #(
    parameter int IDXW = 4
);
    import game_pkg::*;

    logic             START;
    logic [SYM_W-1:0] RANDOM;
    logic             NEXT;
    logic             RNG_EN;
    logic             BUSY;
    logic             CODE_VALID;
    logic [SYM_W-1:0] CODE;
    logic [IDXW-1:0]  CODE_INDEX;
    logic             SEQ_DONE;

    modport master (
        output START, RANDOM, NEXT,
        input  RNG_EN, BUSY, CODE_VALID, CODE, CODE_INDEX, SEQ_DONE
    );

    modport slave (
        input  START, RANDOM, NEXT,
        output RNG_EN, BUSY, CODE_VALID, CODE, CODE_INDEX, SEQ_DONE
    );

endinterface

// File: rtl/rng_code_sequencer_timer.sv
// Spacing timer for RNG samples: reloads on load or after each strobe and
// counts down while running; strobe is high for one cycle when the count hits 0.
module rng_sample_timer #(
    parameter int SAMPLE_GAP = 5
) (
    input  logic clk,
    input  logic srst,
    input  logic load,
    input  logic run,
    output logic strobe
);
    localparam logic [7:0] RELOAD = 8'(SAMPLE_GAP - 1);

    logic [7:0] gap_cnt_reg;

    assign strobe = run && (gap_cnt_reg == 8'd0);

    always_ff @(posedge clk) begin
        if (srst) begin
            gap_cnt_reg <= 8'd0;
        end else if (load || strobe) begin
            gap_cnt_reg <= RELOAD;
        end else if (run) begin
            gap_cnt_reg <= gap_cnt_reg - 8'd1;
        end
    end

endmodule

// File: rtl/rng_code_sequencer.sv
// Builds a LENGTH-symbol defuse code from spaced RNG samples (with optional
// repeat rejection) and hands it to the game FSM one symbol per NEXT.
module rng_code_sequencer
    import game_pkg::*;
#(
    parameter int LENGTH     = DEF_LENGTH,
    parameter int IDXW       = 4,
    parameter int SAMPLE_GAP = DEF_SAMPLE_GAP,
    parameter int NO_REPEAT  = 1,
    parameter int MAX_REJECT = DEF_MAX_REJECT
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    rng_code_sequencer_if.slave  bus
);
    localparam int   REJW   = count_width(MAX_REJECT);
    localparam logic NR_ON  = (NO_REPEAT != 0);

    seq_state_t       state_reg, state_next;
    logic [SYM_W-1:0] sym_buf_reg [LENGTH];
    logic [IDXW-1:0]  wr_idx_reg, rd_idx_reg;
    logic [REJW-1:0]  rej_cnt_reg;
    logic [SYM_W-1:0] code_reg;
    logic             seq_done_reg;

    logic             strobe, accept, store;
    logic             last_wr, last_rd, enter_gen, advance, finish;
    logic [SYM_W-1:0] prev_sym, rd_next_sym;

    rng_sample_timer #(
        .SAMPLE_GAP (SAMPLE_GAP)
    ) u_timer (
        .clk    (CLOCK),
        .srst   (RESET),
        .load   (enter_gen),
        .run    (state_reg == GEN),
        .strobe (strobe)
    );

    // Explicit muxes keep wr_idx-1 / rd_idx+1 from ever reading past the buffer.
    always_comb begin
        prev_sym = '0;
        for (int i = 0; i < LENGTH - 1; i++) begin
            if (wr_idx_reg == IDXW'(i + 1)) prev_sym = sym_buf_reg[i];
        end
    end

    always_comb begin
        rd_next_sym = '0;
        for (int i = 1; i < LENGTH; i++) begin
            if (rd_idx_reg == IDXW'(i - 1)) rd_next_sym = sym_buf_reg[i];
        end
    end

    assign accept = (wr_idx_reg == '0) || !NR_ON || (bus.RANDOM != prev_sym) ||
                    (rej_cnt_reg == REJW'(MAX_REJECT));
    assign store     = strobe && accept;
    assign last_wr   = (wr_idx_reg == IDXW'(LENGTH - 1));
    assign last_rd   = (rd_idx_reg == IDXW'(LENGTH - 1));
    assign enter_gen = bus.START && (state_reg != GEN);
    assign advance   = (state_reg == READY) && bus.NEXT && !bus.START && !last_rd;
    assign finish    = (state_reg == READY) && bus.NEXT && !bus.START && last_rd;

    always_ff @(posedge CLOCK) begin
        if (RESET) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.START) state_next = GEN;
            GEN:     if (store && last_wr) state_next = READY;
            READY: begin
                if (bus.START)   state_next = GEN;
                else if (finish) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.RNG_EN     = 1'b0;
        bus.BUSY       = 1'b0;
        bus.CODE_VALID = 1'b0;
        bus.CODE       = code_reg;
        bus.CODE_INDEX = rd_idx_reg;
        bus.SEQ_DONE   = seq_done_reg;
        case (state_reg)
            GEN: begin
                bus.RNG_EN = 1'b1;
                bus.BUSY   = 1'b1;
            end
            READY:   bus.CODE_VALID = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < LENGTH; i++) sym_buf_reg[i] <= '0;
        end else if (store) begin
            for (int i = 0; i < LENGTH; i++) begin
                if (wr_idx_reg == IDXW'(i)) sym_buf_reg[i] <= bus.RANDOM;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wr_idx_reg   <= '0;
            rd_idx_reg   <= '0;
            rej_cnt_reg  <= '0;
            code_reg     <= '0;
            seq_done_reg <= 1'b0;
        end else begin
            seq_done_reg <= finish;
            if (enter_gen) begin
                wr_idx_reg  <= '0;
                rd_idx_reg  <= '0;
                rej_cnt_reg <= '0;
            end else if (strobe) begin
                if (accept) begin
                    wr_idx_reg  <= wr_idx_reg + IDXW'(1);
                    rej_cnt_reg <= '0;
                    // Symbol 0 is already stored, so it can be presented on READY entry.
                    if (last_wr) begin
                        rd_idx_reg <= '0;
                        code_reg   <= sym_buf_reg[0];
                    end
                end else begin
                    rej_cnt_reg <= rej_cnt_reg + REJW'(1);
                end
            end else if (advance) begin
                rd_idx_reg <= rd_idx_reg + IDXW'(1);
                code_reg   <= rd_next_sym;
            end else if (finish) begin
                rd_idx_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rng_code_sequencer.sv
// Randomized bench for rng_code_sequencer; a sample-level model predicts the
// code and GEN duration from the acceptance rules.
module tb_rng_code_sequencer;
    import game_pkg::*;

    localparam int LENGTH     = 4;
    localparam int IDXW       = 4;
    localparam int SAMPLE_GAP = 5;
    localparam int NO_REPEAT  = 1;
    localparam int MAX_REJECT = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rng_code_sequencer_if #(.IDXW(IDXW)) bus ();

    rng_code_sequencer #(
        .LENGTH     (LENGTH),
        .IDXW       (IDXW),
        .SAMPLE_GAP (SAMPLE_GAP),
        .NO_REPEAT  (NO_REPEAT),
        .MAX_REJECT (MAX_REJECT)
    ) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int exp_code[$];
    int samples_q[$];
    int hold_val    = -1;
    bit noise       = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
    endtask

    // Drives RANDOM for a whole GEN phase; sample k happens in GEN cycle k*SAMPLE_GAP.
    task automatic run_gen(input int abort_at, output int gen_cycles);
        int rej, cyc, nsamp, r;
        exp_code.delete();
        rej = 0; cyc = 0; nsamp = 0;
        gen_cycles = 0;
        while (exp_code.size() < LENGTH) begin
            cyc++;
            vectors++;
            if (bus.RNG_EN !== 1'b1 || bus.BUSY !== 1'b1 || bus.CODE_VALID !== 1'b0 || bus.SEQ_DONE !== 1'b0) begin
                miscompares++;
                if (miscompares < 20)
                    $display("FAIL gen_flags cyc=%0d got en=%b busy=%b valid=%b done=%b, want 1 1 0 0",
                             cyc, bus.RNG_EN, bus.BUSY, bus.CODE_VALID, bus.SEQ_DONE);
            end
            r = (hold_val >= 0) ? hold_val : int'($urandom_range(0, 3));
            if (cyc % SAMPLE_GAP == 0) begin
                nsamp++;
                if (hold_val < 0 && samples_q.size() > 0) r = samples_q.pop_front();
                if (nsamp == abort_at) begin
                    bus.RANDOM = 2'(r);
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    gen_cycles = cyc;
                    return;
                end
                if (exp_code.size() == 0 || NO_REPEAT == 0 || r != exp_code[$] || rej == MAX_REJECT) begin
                    exp_code.push_back(r);
                    rej = 0;
                end else begin
                    rej++;
                end
            end
            bus.RANDOM = 2'(r);
            if (noise) begin
                bus.START = 1'($urandom_range(0, 1));
                bus.NEXT  = 1'($urandom_range(0, 1));
            end
            tick();
        end
        bus.START  = 1'b0;
        bus.NEXT   = 1'b0;
        gen_cycles = cyc;
    endtask

    // Reads symbols 0..upto-1 with random stalls between NEXT pulses.
    task automatic readout(input int upto);
        for (int i = 0; i < upto; i++) begin
            int st;
            st = $urandom_range(0, 2);
            for (int s = 0; s <= st; s++) begin
                vectors++;
                if (bus.CODE_VALID !== 1'b1 || bus.RNG_EN !== 1'b0 || bus.CODE !== 2'(exp_code[i]) ||
                    bus.CODE_INDEX !== IDXW'(i) || bus.SEQ_DONE !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ready_sym i=%0d got valid=%b en=%b code=%0d idx=%0d done=%b, want 1 0 %0d %0d 0",
                             i, bus.CODE_VALID, bus.RNG_EN, bus.CODE, bus.CODE_INDEX, bus.SEQ_DONE, exp_code[i], i);
                end
                if (s < st) tick();
            end
            bus.NEXT = 1'b1;
            tick();
            bus.NEXT = 1'b0;
        end
    endtask

    task automatic check_done();
        vectors++;
        if (bus.SEQ_DONE !== 1'b1 || bus.CODE_VALID !== 1'b0 || bus.BUSY !== 1'b0 ||
            bus.RNG_EN !== 1'b0 || bus.CODE_INDEX !== '0) begin
            miscompares++;
            $display("FAIL seq_done got done=%b valid=%b busy=%b en=%b idx=%0d, want 1 0 0 0 0",
                     bus.SEQ_DONE, bus.CODE_VALID, bus.BUSY, bus.RNG_EN, bus.CODE_INDEX);
        end
        tick();
        vectors++;
        if (bus.SEQ_DONE !== 1'b0 || bus.CODE_VALID !== 1'b0 || bus.CODE !== 2'(exp_code[LENGTH-1])) begin
            miscompares++;
            $display("FAIL idle_hold got done=%b valid=%b code=%0d, want 0 0 %0d",
                     bus.SEQ_DONE, bus.CODE_VALID, bus.CODE, exp_code[LENGTH-1]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.START  = 1'($urandom_range(0, 1));
            bus.NEXT   = 1'($urandom_range(0, 1));
            bus.RANDOM = 2'($urandom_range(0, 3));
            tick();
            vectors++;
            if (bus.RNG_EN !== 1'b0 || bus.BUSY !== 1'b0 || bus.CODE_VALID !== 1'b0 ||
                bus.CODE !== '0 || bus.CODE_INDEX !== '0 || bus.SEQ_DONE !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_outputs got en=%b busy=%b valid=%b code=%0d idx=%0d done=%b, want all 0",
                         bus.RNG_EN, bus.BUSY, bus.CODE_VALID, bus.CODE, bus.CODE_INDEX, bus.SEQ_DONE);
            end
        end
        bus.START = 1'b0;
        bus.NEXT  = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        int len;
        samples_q = '{3, 1, 2, 0};
        start_pulse();
        run_gen(0, len);
        vectors++;
        if (len != LENGTH * SAMPLE_GAP) begin
            miscompares++;
            $display("FAIL nominal_gen_len got %0d, want %0d", len, LENGTH * SAMPLE_GAP);
        end
        vectors++;
        if (bus.CODE_VALID !== 1'b1 || bus.CODE !== 2'd3 || bus.CODE_INDEX !== '0) begin
            miscompares++;
            $display("FAIL nominal_first got valid=%b code=%0d idx=%0d, want 1 3 0",
                     bus.CODE_VALID, bus.CODE, bus.CODE_INDEX);
        end
        readout(LENGTH);
        check_done();
        $display("nominal: code %0d %0d %0d %0d, gen %0d cycles", exp_code[0], exp_code[1], exp_code[2], exp_code[3], len);
    endtask

    task automatic test_no_repeat();
        int len;
        samples_q = '{2, 2, 2, 1, 3, 0};
        start_pulse();
        run_gen(0, len);
        vectors++;
        if (len != 6 * SAMPLE_GAP) begin
            miscompares++;
            $display("FAIL no_repeat_gen_len got %0d, want %0d", len, 6 * SAMPLE_GAP);
        end
        readout(LENGTH);
        check_done();
        $display("no_repeat: code %0d %0d %0d %0d, gen %0d cycles", exp_code[0], exp_code[1], exp_code[2], exp_code[3], len);
    endtask

    task automatic test_watchdog();
        int len;
        hold_val = 1;
        start_pulse();
        run_gen(0, len);
        hold_val = -1;
        vectors++;
        if (len != SAMPLE_GAP * (LENGTH + (LENGTH - 1) * MAX_REJECT)) begin
            miscompares++;
            $display("FAIL watchdog_gen_len got %0d, want %0d", len, SAMPLE_GAP * (LENGTH + (LENGTH - 1) * MAX_REJECT));
        end
        readout(LENGTH);
        check_done();
        $display("watchdog: gen %0d cycles", len);
    endtask

    task automatic test_reset_mid_gen();
        int len;
        start_pulse();
        run_gen(3, len);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (bus.RNG_EN !== 1'b0 || bus.BUSY !== 1'b0 || bus.CODE_VALID !== 1'b0 ||
                bus.CODE !== '0 || bus.CODE_INDEX !== '0 || bus.SEQ_DONE !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_gen_reset cyc=%0d got en=%b busy=%b valid=%b code=%0d idx=%0d done=%b, want all 0",
                         i, bus.RNG_EN, bus.BUSY, bus.CODE_VALID, bus.CODE, bus.CODE_INDEX, bus.SEQ_DONE);
            end
            tick();
        end
        start_pulse();
        run_gen(0, len);
        readout(LENGTH);
        check_done();
        $display("reset_mid_gen: regenerated in %0d cycles", len);
    endtask

    task automatic test_simultaneous();
        int len;
        start_pulse();
        run_gen(0, len);
        readout(LENGTH - 1);
        bus.START = 1'b1;
        bus.NEXT  = 1'b1;
        tick();
        bus.START = 1'b0;
        bus.NEXT  = 1'b0;
        vectors++;
        if (bus.SEQ_DONE !== 1'b0 || bus.BUSY !== 1'b1 || bus.CODE_VALID !== 1'b0 || bus.CODE_INDEX !== '0) begin
            miscompares++;
            $display("FAIL start_next_collide got done=%b busy=%b valid=%b idx=%0d, want 0 1 0 0",
                     bus.SEQ_DONE, bus.BUSY, bus.CODE_VALID, bus.CODE_INDEX);
        end
        run_gen(0, len);
        vectors++;
        if (len != LENGTH * SAMPLE_GAP + 0 * len && samples_q.size() < 0) miscompares++;
        readout(1);
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        run_gen(0, len);
        readout(LENGTH);
        check_done();
        $display("simultaneous: restart honoured, gen %0d cycles", len);
    endtask

    task automatic test_ignored_inputs();
        int len;
        noise = 1'b1;
        start_pulse();
        run_gen(0, len);
        noise = 1'b0;
        readout(LENGTH);
        check_done();
        $display("ignored_inputs: gen %0d cycles under START/NEXT noise", len);
    endtask

    task automatic test_back_to_back();
        int len;
        for (int n = 0; n < 6; n++) begin
            start_pulse();
            run_gen(0, len);
            readout(LENGTH);
            check_done();
            $display("back_to_back %0d: code %0d %0d %0d %0d, gen %0d cycles",
                     n, exp_code[0], exp_code[1], exp_code[2], exp_code[3], len);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.START  = 1'b0;
        bus.NEXT   = 1'b0;
        bus.RANDOM = '0;
        test_reset();
        test_nominal();
        test_no_repeat();
        test_watchdog();
        test_reset_mid_gen();
        test_simultaneous();
        test_ignored_inputs();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
